// File: rtl/dcache_rep_lru.sv
// True-LRU replacement unit for the set-associative data cache.
// Tracks per-set age permutations and per-way valid bits, and returns a registered victim way.
module dcache_rep_lru #(
    parameter int SETS  = 8,
    parameter int WAYS  = 4,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inv_all,
    output logic             ready,
    input  logic             lookup_en,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic [WAY_W-1:0] way,
    output logic             way_valid,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             match,
    input  logic [WAY_W-1:0] match_idx,
    input  logic             upd_fill
);

    typedef enum logic {INIT, IDLE} state_t;

    state_t                             state, state_nx;
    logic [IDX_W-1:0]                   cnt;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age;
    logic [SETS-1:0][WAYS-1:0]          vld;

    logic                               init_we, act, upd_act, lkp_act;
    logic [WAY_W-1:0]                   a;
    logic [WAYS-1:0][WAY_W-1:0]         upd_age, sel_age;
    logic [WAYS-1:0]                    upd_vld, sel_vld;
    logic [WAY_W-1:0]                   victim;
    logic                               found;

    always_ff @(posedge CLK) begin
        if (RST) state <= INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (inv_all)
            state_nx = INIT;
        else if (state == INIT && cnt == IDX_W'(SETS - 1))
            state_nx = IDLE;
    end

    always_comb begin
        ready   = (state == IDLE);
        init_we = (state == INIT);
        act     = (state == IDLE) && !inv_all;
        upd_act = act && upd_en && (match || upd_fill);
        lkp_act = act && lookup_en;
    end

    // Post-update view of the updated set; also used to bypass same-set lookups.
    always_comb begin
        a       = age[upd_idx][match_idx];
        upd_vld = vld[upd_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == match_idx)
                upd_age[w] = '0;
            else if (age[upd_idx][w] < a)
                upd_age[w] = age[upd_idx][w] + WAY_W'(1);
            else
                upd_age[w] = age[upd_idx][w];
        end
        if (upd_fill) upd_vld[match_idx] = 1'b1;
    end

    always_comb begin
        if (upd_act && lookup_idx == upd_idx) begin
            sel_age = upd_age;
            sel_vld = upd_vld;
        end else begin
            sel_age = age[lookup_idx];
            sel_vld = vld[lookup_idx];
        end
        victim = '0;
        found  = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!sel_vld[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++)
                if (sel_age[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            way       <= '0;
            way_valid <= 1'b0;
        end else begin
            cnt       <= (inv_all || state == IDLE) ? '0 : cnt + 1'b1;
            way_valid <= lkp_act;
            if (lkp_act) way <= victim;
        end
    end

    // Array contents need no reset: the init sweep rewrites every set.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (init_we) begin
                for (int w = 0; w < WAYS; w++)
                    age[cnt][w] <= WAY_W'(w);
                vld[cnt] <= '0;
            end else if (upd_act) begin
                age[upd_idx] <= upd_age;
                vld[upd_idx] <= upd_vld;
            end
        end
    end

endmodule

// File: tb/tb_dcache_rep_lru.sv
// Scoreboard bench for dcache_rep_lru: directed lookups push expected victims, a monitor pops on way_valid.
module tb_dcache_rep_lru;

    localparam int SETS = 8, WAYS = 4, IDX_W = 3, WAY_W = 2;

    logic             CLK = 0, RST = 1, inv_all = 0;
    logic             ready, way_valid;
    logic             lookup_en = 0, upd_en = 0, match = 0, upd_fill = 0;
    logic [IDX_W-1:0] lookup_idx = 0, upd_idx = 0;
    logic [WAY_W-1:0] match_idx = 0, way;

    int n_chk = 0, n_fail = 0, n_vic = 0;
    int exp_q[$];

    dcache_rep_lru #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK(CLK), .RST(RST), .inv_all(inv_all), .ready(ready),
        .lookup_en(lookup_en), .lookup_idx(lookup_idx), .way(way), .way_valid(way_valid),
        .upd_en(upd_en), .upd_idx(upd_idx), .match(match), .match_idx(match_idx),
        .upd_fill(upd_fill)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (way_valid) begin
            n_chk++;
            n_vic++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_way_valid #%0d got way=%0d want no way_valid", n_vic, way);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(way) != e) begin
                    n_fail++;
                    $display("FAIL victim #%0d got %0d want %0d", n_vic, way, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic lookup(input int idx, input int exp);
        lookup_en = 1; lookup_idx = IDX_W'(idx);
        exp_q.push_back(exp);
        tick();
        lookup_en = 0;
    endtask

    task automatic upd(input int idx, input int w, input logic m, input logic f);
        upd_en = 1; upd_idx = IDX_W'(idx); match_idx = WAY_W'(w); match = m; upd_fill = f;
        tick();
        upd_en = 0; match = 0; upd_fill = 0;
    endtask

    // Expects ready low for exactly SETS samples, then high.
    task automatic check_init(input string name);
        for (int i = 0; i < SETS; i++) begin
            check({name, "_ready_low"}, int'(ready), 0);
            tick();
        end
        check({name, "_ready_high"}, int'(ready), 1);
    endtask

    initial begin
        RST = 1;
        tick();
        check("reset_ready", int'(ready), 0);
        check("reset_way_valid", int'(way_valid), 0);
        tick();
        RST = 0;
        lookup_en = 1; lookup_idx = 3;
        check_init("reset");
        lookup_en = 0;

        // Invalid-first fill order on set 3
        for (int w = 0; w < WAYS; w++) begin
            lookup(3, w);
            upd(3, w, 0, 1);
        end
        lookup(3, 0);

        // LRU ordering on set 5
        for (int w = 0; w < WAYS; w++) upd(5, w, 0, 1);
        upd(5, 0, 1, 0);
        upd(5, 2, 1, 0);
        lookup(5, 1);
        upd(5, 1, 1, 0);
        lookup(5, 3);

        // Set 6 full, ages [3,2,1,0]
        for (int w = 0; w < WAYS; w++) upd(6, w, 0, 1);
        lookup(6, 0);

        // Same-set bypass: hit way 3 with concurrent lookup
        upd_en = 1; upd_idx = 5; match = 1; match_idx = 3;
        lookup(5, 0);
        upd_en = 0; match = 0;
        lookup(6, 0);

        // Different sets in the same cycle are independent
        upd_en = 1; upd_idx = 6; match = 1; match_idx = 0;
        lookup(5, 0);
        upd_en = 0; match = 0;
        lookup(6, 1);

        // No-op updates
        upd(2, 0, 0, 1);
        lookup(2, 1);
        upd(2, 1, 0, 0);
        lookup(2, 1);
        upd(5, 0, 0, 0);
        lookup(5, 0);

        // inv_all with concurrent lookup, then restart mid-sweep
        for (int w = 0; w < WAYS; w++) upd(1, w, 0, 1);
        lookup(1, 0);
        inv_all = 1; lookup_en = 1; lookup_idx = 1;
        tick();
        inv_all = 0; lookup_en = 0;
        check_init("inv_all");
        tick(); tick(); tick();
        inv_all = 1;
        tick();
        inv_all = 0;
        check_init("inv_restart");
        lookup(1, 0);
        upd(1, 0, 0, 1);
        lookup(1, 1);
        lookup(3, 0);

        // Reset mid-lookup suppresses way_valid
        lookup_en = 1; lookup_idx = 3; RST = 1;
        tick();
        lookup_en = 0; RST = 0;
        check("rst_mid_lookup_way_valid", int'(way_valid), 0);
        check("rst_mid_lookup_ready", int'(ready), 0);

        tick(); tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_rep_lru.md
Name: dcache_rep_lru

Overview:
- Replacement-policy unit for the set-associative data cache. It is the consumer of the cache controller's replacement outputs (match, match_idx) and the producer of the victim way index (way).
- Holds per-set true-LRU age state and per-way valid bits. It answers victim lookups one cycle after request.
- Sits beside the dcache controller, between the tag-compare logic and the fill/writeback path.

Parameters:
SETS, 8, number of cache sets (power of two)
WAYS, 4, associativity (power of two, 2..8)
IDX_W, $clog2(SETS), set index width
WAY_W, $clog2(WAYS), way index width (equals MRU in the caches types package)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous active-high reset
inv_all  input  1  pulse: invalidate all sets and restart init sweep (used on halt/flush)
ready  output  1  high when in IDLE; lookups and updates are ignored while low
lookup_en  input  1  request victim way for lookup_idx
lookup_idx  input  IDX_W  set index of lookup
way  output  WAY_W  victim way, registered
way_valid  output  1  one-cycle pulse qualifying way
upd_en  input  1  access update strobe
upd_idx  input  IDX_W  set index of update
match  input  1  update is a hit
match_idx  input  WAY_W  way accessed (hit way or filled way)
upd_fill  input  1  update is a fill; sets valid bit of match_idx

Behaviour:
- State: age[s][w] (WAY_W bits) and valid[s][w] (1 bit). Within each set, ages are always a permutation of 0..WAYS-1.
- FSM states: INIT, IDLE.
- RST (synchronous): FSM <= INIT, init counter <= 0, way <= 0, way_valid <= 0, ready <= 0.
- INIT: one set per cycle, at set = counter. For each w, age[set][w] <= w and valid[set][w] <= 0. Counter increments each cycle.
- INIT lasts exactly SETS cycles. On the cycle after the last set is written, FSM = IDLE and ready = 1.
- lookup_en and upd_en are ignored in INIT, and way_valid stays 0.
- inv_all in any state: next cycle FSM = INIT, counter = 0, ready = 0. Any lookup or update in the same cycle is dropped. inv_all during INIT restarts the sweep from 0.
- Access update (IDLE, upd_en=1, and match=1 or upd_fill=1), let a = age[upd_idx][match_idx]:
  - every way with age < a increments;
  - age[upd_idx][match_idx] <= 0;
  - ways with age > a are unchanged;
  - if upd_fill=1, valid[upd_idx][match_idx] <= 1.
- upd_en with match=0 and upd_fill=0 is a no-op.
- Victim select for set s:
  - if any valid bit is 0, choose the lowest-index invalid way;
  - otherwise choose the way with age == WAYS-1.
- Lookup latency: lookup_en=1 at cycle N (IDLE) gives way and way_valid=1 at cycle N+1. way_valid is 0 otherwise; way holds its last value.
- Back-to-back lookups every cycle are supported.
- Same-cycle lookup and update to the same set: the victim is computed from the post-update state (bypass), so a just-hit way is never returned as victim when WAYS>1.
- Same-cycle lookup and update to different sets: independent.
- Reset mid-sweep or mid-lookup: RST wins over inv_all and all other inputs. The pending way_valid is suppressed.

Test Plan:
- Reset: RST high 2 cycles then low -> ready=0 for exactly 8 cycles, ready=1 on the 9th. way_valid never asserted during INIT, even with lookup_en held high.
- Invalid-first fill order: set 3, do lookup/fill-with-returned-way 4 times -> victims 0,1,2,3. Then a lookup returns 0, which is the LRU way.
- LRU ordering: set 5 all filled in order 0,1,2,3; hit way 0 then way 2 -> lookup returns 1. Hit way 1 -> lookup returns 3.
- Bypass: set 5 in the state above, same cycle upd hit way 3 and lookup set 5 -> way=0 next cycle, not 3. Set 6 unchanged by the access.
- No-op update: upd_en=1, match=0, upd_fill=0 on set 2 -> subsequent lookup results for set 2 identical to before.
- inv_all: after filling set 1 fully, pulse inv_all alongside lookup_en -> no way_valid, ready low 8 cycles. Then lookup set 1 returns 0 and a fill of way 0 makes the next lookup return 1.
